// File: rtl/bus_interconnect.sv
// Byte-wide CPU-to-peripheral fabric: window decode, wait states, timeout and unmapped-address fault.
// Optional fault logging (fault_address/fault_count/fault_clear) when BUS_FAULT_LOG_EN is defined.
module bus_interconnect #(
  parameter int unsigned                NUM_SLAVES     = 4,
  parameter logic [NUM_SLAVES*32-1:0]   SLAVE_BASES    = {32'h0000_3000, 32'h0000_2000,
                                                          32'h0000_1000, 32'h0000_0000},
  parameter logic [NUM_SLAVES*32-1:0]   SLAVE_SIZES    = {4{32'h0000_1000}},
  parameter int unsigned                TIMEOUT_CYCLES = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [31:0]               cpu_address,
  input  logic [7:0]                cpu_write_data,
  input  logic                      cpu_write_enable,
  input  logic                      cpu_read_enable,
  output logic [7:0]                cpu_read_data,
  output logic                      cpu_ready,
  output logic                      cpu_fault,
  output logic [NUM_SLAVES-1:0]     slv_select,
  output logic [31:0]               slv_address,
  output logic [7:0]                slv_write_data,
  output logic                      slv_write_enable,
  input  logic [NUM_SLAVES*8-1:0]   slv_read_data,
  input  logic [NUM_SLAVES-1:0]     slv_ready
`ifdef BUS_FAULT_LOG_EN
  ,
  output logic [31:0]               fault_address,
  output logic [7:0]                fault_count,
  input  logic                      fault_clear
`endif
);

  localparam int unsigned AW    = 32;
  localparam int unsigned DW    = 8;
  localparam int unsigned IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;
  localparam logic [1:0] S_FAULT  = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d, hit_idx;
  logic                  wr_q, wr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  hit, req, timeout_hit;
  logic [AW-1:0]         hit_off, win_base, win_size;
  logic [AW:0]           diff;
  logic [NUM_SLAVES-1:0] sel_d;
  logic [AW-1:0]         saddr_d;
  logic [DW-1:0]         swd_d, rdata_d;
  logic                  swe_d, rdy_d, flt_d;

  assign req         = cpu_write_enable | cpu_read_enable;
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // Window decode in 33 bits; scanning downward leaves the lowest matching index.
  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    hit_off  = '0;
    win_base = '0;
    win_size = '0;
    diff     = '0;
    for (int i = int'(NUM_SLAVES) - 1; i >= 0; i--) begin
      win_base = SLAVE_BASES[32*i +: 32];
      win_size = SLAVE_SIZES[32*i +: 32];
      diff     = {1'b0, cpu_address} - {1'b0, win_base};
      if ((win_size != '0) && !diff[AW] && (diff < {1'b0, win_size})) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
        hit_off = diff[AW-1:0];
      end
    end
  end

  // Next state plus next value of every registered output.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wr_d    = wr_q;
    cnt_d   = cnt_q;
    sel_d   = '0;
    saddr_d = '0;
    swd_d   = '0;
    swe_d   = 1'b0;
    rdata_d = '0;
    rdy_d   = 1'b0;
    flt_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          idx_d = hit_idx;
          wr_d  = cpu_write_enable;
          cnt_d = '0;
          if (hit) begin
            state_d = S_ACCESS;
            sel_d   = NUM_SLAVES'(1) << hit_idx;
            saddr_d = hit_off;
            swd_d   = cpu_write_data;
            swe_d   = cpu_write_enable;
          end else begin
            state_d = S_FAULT;
            rdy_d   = 1'b1;
            flt_d   = 1'b1;
          end
        end
      end
      S_ACCESS: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (slv_ready[idx_q]) begin
          state_d = S_RESP;
          rdy_d   = 1'b1;
          rdata_d = wr_q ? '0 : slv_read_data[DW*idx_q +: DW];
        end else if (timeout_hit) begin
          state_d = S_FAULT;
          rdy_d   = 1'b1;
          flt_d   = 1'b1;
        end else begin
          sel_d   = slv_select;
          saddr_d = slv_address;
          swd_d   = slv_write_data;
          swe_d   = slv_write_enable;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q          <= S_IDLE;
      idx_q            <= '0;
      wr_q             <= 1'b0;
      cnt_q            <= '0;
      slv_select       <= '0;
      slv_address      <= '0;
      slv_write_data   <= '0;
      slv_write_enable <= 1'b0;
      cpu_read_data    <= '0;
      cpu_ready        <= 1'b0;
      cpu_fault        <= 1'b0;
    end else begin
      state_q          <= state_d;
      idx_q            <= idx_d;
      wr_q             <= wr_d;
      cnt_q            <= cnt_d;
      slv_select       <= sel_d;
      slv_address      <= saddr_d;
      slv_write_data   <= swd_d;
      slv_write_enable <= swe_d;
      cpu_read_data    <= rdata_d;
      cpu_ready        <= rdy_d;
      cpu_fault        <= flt_d;
    end
  end

`ifdef BUS_FAULT_LOG_EN
  logic [AW-1:0] addr_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q <= '0;
    end else if ((state_q == S_IDLE) && req) begin
      addr_q <= cpu_address;
    end
  end

  // A miss faults straight from IDLE with the live address; a timeout uses the latched one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fault_address <= '0;
      fault_count   <= '0;
    end else if (fault_clear) begin
      fault_address <= '0;
      fault_count   <= '0;
    end else if (state_d == S_FAULT) begin
      fault_address <= (state_q == S_IDLE) ? cpu_address : addr_q;
      if (fault_count != 8'hFF) fault_count <= fault_count + 8'd1;
    end
  end
`endif

endmodule
